// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the fetch FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Pipeline-side signals of the fetch PC unit, plus its FSM state for observation.
interface fetch_pc_unit_if #(
  parameter int CNT_W = 16
) ();
  import mips_pkg::*;

  // ID offers a decision when ID_Valid=1 and Stall_ID=0; it is consumed only if taken
  // and the opcode is a branch/jump. IF takes a new PC only in cycles with Stall_IF=0.
  logic             Stall_IF;
  logic             Stall_ID;
  logic             ID_Valid;
  logic [31:0]      Instr_ID;
  logic [31:0]      PC_ID;
  logic [31:0]      OpA;
  logic             taken;
  logic [31:0]      PC_IF;
  logic             Redirect;
  logic [31:0]      Link_Addr;
  logic             Addr_Err;
  logic [CNT_W-1:0] Redir_Count;
  fsm_state_t       state;

  modport master (
    output Stall_IF, Stall_ID, ID_Valid, Instr_ID, PC_ID, OpA, taken,
    input  PC_IF, Redirect, Link_Addr, Addr_Err, Redir_Count, state
  );

  modport slave (
    input  Stall_IF, Stall_ID, ID_Valid, Instr_ID, PC_ID, OpA, taken,
    output PC_IF, Redirect, Link_Addr, Addr_Err, Redir_Count, state
  );

endinterface

// File: rtl/branch_target_calc.sv
// Combinational redirect target for the instruction in ID: branch, J/JAL or JR/JALR.
module branch_target_calc
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc_id,
  input  logic [31:0] op_a,
  output logic [31:0] target,
  output logic        valid,
  output logic        misaligned
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] raw;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign pc_plus4 = pc_id + 32'd4;
  assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    raw   = 32'h0;
    valid = 1'b0;
    case (opcode)
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        raw   = pc_plus4 + br_off;
        valid = 1'b1;
      end
      OP_J, OP_JAL: begin
        raw   = {pc_plus4[31:28], instr[25:0], 2'b00};
        valid = 1'b1;
      end
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          raw   = op_a;
          valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Only a register target can be misaligned; the fetch address is always word aligned.
  assign target     = {raw[31:2], 2'b00};
  assign misaligned = |raw[1:0];

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage program counter with delayed (post delay-slot) redirect and stall-tolerant pending target.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter int          CNT_W        = 16
) (
  input logic            CLK,
  input logic            RESET,
  fetch_pc_unit_if.slave bus
);

  fsm_state_t       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic             pend_err_q, pend_err_d;
  logic             redirect_q, redirect_d;
  logic             addr_err_q, addr_err_d;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      tgt;
  logic             tgt_valid;
  logic             tgt_mis;
  logic             accept;

  branch_target_calc u_calc (
    .instr      (bus.Instr_ID),
    .pc_id      (bus.PC_ID),
    .op_a       (bus.OpA),
    .target     (tgt),
    .valid      (tgt_valid),
    .misaligned (tgt_mis)
  );

  assign accept = bus.ID_Valid & ~bus.Stall_ID & bus.taken & tgt_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_err_d = pend_err_q;
    redirect_d = 1'b0;
    addr_err_d = 1'b0;
    case (state_q)
      RUN: begin
        if (accept && !bus.Stall_IF) begin
          pc_d       = tgt;
          redirect_d = 1'b1;
          addr_err_d = tgt_mis;
        end else if (accept) begin
          pend_tgt_d = tgt;
          pend_err_d = tgt_mis;
          state_d    = PENDING;
        end else if (!bus.Stall_IF) begin
          pc_d = pc_q + 32'd4;
        end
      end
      PENDING: begin
        // A fresh decision always beats the stored one, whether released now or later.
        if (!bus.Stall_IF) begin
          pc_d       = accept ? tgt : pend_tgt_q;
          addr_err_d = accept ? tgt_mis : pend_err_q;
          redirect_d = 1'b1;
          state_d    = RUN;
        end else if (accept) begin
          pend_tgt_d = tgt;
          pend_err_d = tgt_mis;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= RUN;
      pc_q       <= RESET_VECTOR;
      pend_tgt_q <= 32'h0;
      pend_err_q <= 1'b0;
      redirect_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_err_q <= pend_err_d;
      redirect_q <= redirect_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Counts on the same edge that raises Redirect, so the two are visible together.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else if (redirect_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.PC_IF       = pc_q;
  assign bus.Redirect    = redirect_q;
  assign bus.Addr_Err    = addr_err_q;
  assign bus.Redir_Count = cnt_q;
  assign bus.Link_Addr   = bus.PC_ID + 32'd8;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized checks of fetch_pc_unit against a cycle-level reference model.
module tb_fetch_pc_unit;
  import mips_pkg::*;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam int          CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fetch_pc_unit_if #(.CNT_W(CW)) bus ();

  fetch_pc_unit #(.RESET_VECTOR(RV), .CNT_W(CW)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ptgt;
  int          m_cnt;
  bit          m_redir;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RV;
    m_pend  = 1'b0;
    m_ptgt  = 32'h0;
    m_cnt   = 0;
    m_redir = 1'b0;
    m_err   = 1'b0;
  endtask

  // Raw (unaligned) target straight from the instruction-set rules.
  function automatic bit model_target(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [31:0] opa, output logic [31:0] tgt);
    logic [5:0]  op;
    logic [31:0] seq;
    logic [31:0] off;
    op  = instr[31:26];
    seq = pc + 32'd4;
    tgt = 32'h0;
    if (op == 6'd1 || (op >= 6'd4 && op <= 6'd7)) begin
      off = {{16{instr[15]}}, instr[15:0]};
      tgt = seq + off * 32'd4;
      return 1'b1;
    end
    if (op == 6'd2 || op == 6'd3) begin
      tgt = {seq[31:28], instr[25:0], 2'b00};
      return 1'b1;
    end
    if (op == 6'd0 && (instr[5:0] == 6'd8 || instr[5:0] == 6'd9)) begin
      tgt = opa;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_load(input logic [31:0] t);
    m_pc    = {t[31:2], 2'b00};
    m_err   = (t[1:0] != 2'b00);
    m_redir = 1'b1;
  endtask

  task automatic model_step(input bit s_if, input bit s_id, input bit vld,
                            input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] opa, input bit tk);
    logic [31:0] t;
    bit          ok;
    bit          acc;
    ok      = model_target(instr, pc, opa, t);
    acc     = vld && !s_id && tk && ok;
    m_redir = 1'b0;
    m_err   = 1'b0;
    if (m_pend) begin
      if (!s_if) begin
        model_load(acc ? t : m_ptgt);
        m_pend = 1'b0;
      end else if (acc) begin
        m_ptgt = t;
      end
    end else if (acc && !s_if) begin
      model_load(t);
    end else if (acc) begin
      m_pend = 1'b1;
      m_ptgt = t;
    end else if (!s_if) begin
      m_pc = m_pc + 32'd4;
    end
    if (m_redir && m_cnt < (1 << CW) - 1) m_cnt++;
    exp_q.push_back(m_pc);
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_pc;
    exp_pc = exp_q.pop_front();
    check({tag, "_pc"},    bus.PC_IF, exp_pc);
    check({tag, "_redir"}, 32'(bus.Redirect), 32'(m_redir));
    check({tag, "_aerr"},  32'(bus.Addr_Err), 32'(m_err));
    check({tag, "_cnt"},   32'(bus.Redir_Count), 32'(m_cnt));
    check({tag, "_state"}, 32'(bus.state), 32'(m_pend));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string tag, input bit s_if, input bit s_id, input bit vld,
                      input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] opa, input bit tk);
    bus.Stall_IF = s_if;
    bus.Stall_ID = s_id;
    bus.ID_Valid = vld;
    bus.Instr_ID = instr;
    bus.PC_ID    = pc;
    bus.OpA      = opa;
    bus.taken    = tk;
    #1;
    check({tag, "_link"}, bus.Link_Addr, pc + 32'd8);
    model_step(s_if, s_id, vld, instr, pc, opa, tk);
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input bit s_if);
    step(tag, s_if, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  localparam logic [31:0] I_BEQ  = 32'h1000_FFFC;
  localparam logic [31:0] I_J    = 32'h0810_0040;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_ADDI = 32'h2001_0005;

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {6'b000001, r[25:0]};
      1: return {4'b0001, r[27:0]};
      2: return {5'b00001, r[26:0]};
      3: return {6'b000000, r[25:6], 5'b00100, r[0]};
      4: return {6'b000000, r[25:6], 6'b100000};
      default: return r;
    endcase
  endfunction

  initial begin
    bus.Stall_IF = 1'b0;
    bus.Stall_ID = 1'b0;
    bus.ID_Valid = 1'b0;
    bus.Instr_ID = 32'h0;
    bus.PC_ID    = 32'h0;
    bus.OpA      = 32'h0;
    bus.taken    = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_pc",    bus.PC_IF, RV);
    check("rst_redir", 32'(bus.Redirect), 32'd0);
    check("rst_aerr",  32'(bus.Addr_Err), 32'd0);
    check("rst_cnt",   32'(bus.Redir_Count), 32'd0);
    check("rst_state", 32'(bus.state), 32'(RUN));
    rst_n = 1'b1;

    idle("t1a", 1'b0);
    idle("t1b", 1'b0);
    check("t1_pc", bus.PC_IF, 32'h0040_0008);

    step("t2", 1'b0, 1'b0, 1'b1, I_BEQ, 32'h0040_0010, 32'h0, 1'b1);
    check("t2_pc",  bus.PC_IF, 32'h0040_0004);
    check("t2_cnt", 32'(bus.Redir_Count), 32'd1);

    step("t3a", 1'b1, 1'b0, 1'b1, I_J, 32'h0040_0020, 32'h0, 1'b1);
    idle("t3b", 1'b1);
    idle("t3c", 1'b1);
    check("t3_hold",  bus.PC_IF, 32'h0040_0004);
    check("t3_state", 32'(bus.state), 32'(PENDING));
    idle("t3d", 1'b0);
    check("t3_pc",    bus.PC_IF, 32'h0040_0100);
    check("t3_redir", 32'(bus.Redirect), 32'd1);

    step("t4a", 1'b0, 1'b0, 1'b1, I_JR, 32'h0040_0100, 32'h0040_0102, 1'b1);
    check("t4_pc",   bus.PC_IF, 32'h0040_0100);
    check("t4_aerr", 32'(bus.Addr_Err), 32'd1);
    idle("t4b", 1'b0);
    check("t4_aerr_off", 32'(bus.Addr_Err), 32'd0);

    step("t5a", 1'b0, 1'b1, 1'b1, I_BEQ, 32'h0040_0010, 32'h0, 1'b1);
    step("t5b", 1'b0, 1'b0, 1'b0, I_BEQ, 32'h0040_0010, 32'h0, 1'b1);
    step("t5c", 1'b0, 1'b0, 1'b1, I_ADDI, 32'h0040_0010, 32'h0, 1'b1);
    check("t5_pc", bus.PC_IF, 32'h0040_0110);

    // Overwrite while pending, then a release cycle that also carries a new decision.
    step("ova", 1'b1, 1'b0, 1'b1, I_J, 32'h0040_0020, 32'h0, 1'b1);
    step("ovb", 1'b1, 1'b0, 1'b1, I_BEQ, 32'h0040_0010, 32'h0, 1'b1);
    step("ovc", 1'b0, 1'b0, 1'b1, I_JR, 32'h0, 32'h1234_5678, 1'b1);
    check("ov_pc", bus.PC_IF, 32'h1234_5678);

    step("wra", 1'b0, 1'b0, 1'b1, I_JR, 32'h0, 32'hFFFF_FFFC, 1'b1);
    idle("wrb", 1'b0);
    check("wrap_pc", bus.PC_IF, 32'h0);

    step("t6a", 1'b1, 1'b0, 1'b1, I_J, 32'h0040_0020, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_pc",    bus.PC_IF, RV);
    check("t6_state", 32'(bus.state), 32'(RUN));
    check("t6_cnt",   32'(bus.Redir_Count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle("t6b", 1'b0);
    check("t6_after", bus.PC_IF, RV + 32'd4);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc_r;
      pc_r = $urandom;
      step("rnd",
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) != 0),
           rand_instr(),
           {pc_r[31:2], 2'b00},
           $urandom,
           ($urandom_range(0, 1) == 1));
    end

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
